// File: rtl/matrix_loader_if.sv
// ---------------------------------------------------------------------------
// matrix_loader_if
//   Bundles the load-control, element-stream and result-bus signals of the
//   matrix loader.
//
//   Load request : start, m_in[2:0], n_in[2:0]
//   Element beat : elem_data[7:0], elem_valid, elem_ready
//   Result bus   : m[2:0], n[2:0], matrices_out[399:0] ({B, A}),
//                  valid, busy, error
//
//   master : the producer of dimensions and elements (and consumer of the bus)
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface matrix_loader_if;
  logic         start;
  logic [2:0]   m_in;
  logic [2:0]   n_in;
  logic [7:0]   elem_data;
  logic         elem_valid;
  logic         elem_ready;
  logic [2:0]   m;
  logic [2:0]   n;
  logic [399:0] matrices_out;
  logic         valid;
  logic         busy;
  logic         error;

  modport master (
    output start, m_in, n_in, elem_data, elem_valid,
    input  elem_ready, m, n, matrices_out, valid, busy, error
  );

  modport slave (
    input  start, m_in, n_in, elem_data, elem_valid,
    output elem_ready, m, n, matrices_out, valid, busy, error
  );
endinterface

// File: rtl/matrix_loader.sv
// ---------------------------------------------------------------------------
// matrix_loader
//   Accepts a dimension pair (m, n) followed by a serial byte stream of
//   2*m*n elements and packs two m x n matrices row-major into a 400-bit bus:
//   A in bits [199:0], B in bits [399:200], element (i,j) at (i*5+j)*8.
//   Slots outside the m x n window are always zero.
//
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : matrix_loader_if.slave
//            start/m_in/n_in      - load request (legal dims 1..5)
//            elem_data/elem_valid - element stream, accepted when elem_ready
//            elem_ready           - high in LOAD_A/LOAD_B (from registered state)
//            m/n/matrices_out     - latched dims and packed {B, A}
//            valid                - both matrices complete, bus stable
//            busy                 - load in progress
//            error                - last start carried illegal dims
// ---------------------------------------------------------------------------
module matrix_loader (
  input  logic            clk,
  input  logic            reset,
  matrix_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_e;

  state_e       state_q;
  logic [2:0]   row_q;
  logic [2:0]   col_q;
  logic [2:0]   m_q;
  logic [2:0]   n_q;
  logic [399:0] mat_q;
  logic         valid_q;
  logic         busy_q;
  logic         error_q;

  logic         loading;
  logic         accept;
  logic         dims_legal;
  logic         last_col;
  logic         last_elem;
  logic [4:0]   slot;
  logic [8:0]   bit_base;

  assign loading    = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign accept     = loading && bus.elem_valid;
  assign dims_legal = (bus.m_in != 3'd0) && (bus.m_in <= 3'd5) &&
                      (bus.n_in != 3'd0) && (bus.n_in <= 3'd5);
  assign last_col   = (col_q == n_q - 3'd1);
  assign last_elem  = last_col && (row_q == m_q - 3'd1);

  // Bit offset of the current element: slot*8 reaches 192 and B adds 200,
  // so 9 bits are needed to address bit 399.
  assign slot     = 5'(row_q) * 5'd5 + 5'(col_q);
  assign bit_base = {1'b0, slot, 3'b000} + ((state_q == LOAD_B) ? 9'd200 : 9'd0);

  // NOTE: every register below is assigned with <= so all of them sample the
  // pre-edge values together; mixing in = would make results order-dependent.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the 400-bit matrix register is cleared on reset on purpose --
      // downstream relies on unused slots reading as zero, so it is state,
      // not a scratch memory that could be left uninitialised.
      state_q <= IDLE;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      m_q     <= 3'd0;
      n_q     <= 3'd0;
      mat_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            if (dims_legal) begin
              m_q     <= bus.m_in;
              n_q     <= bus.n_in;
              mat_q   <= '0;
              row_q   <= 3'd0;
              col_q   <= 3'd0;
              valid_q <= 1'b0;
              error_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= LOAD_A;
            end else begin
              // Illegal request: keep the previous bus and dims untouched.
              error_q <= 1'b1;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end

        LOAD_A, LOAD_B: begin
          // start is deliberately not looked at here; a load always runs out.
          if (accept) begin
            mat_q[bit_base +: 8] <= bus.elem_data;
            if (last_elem) begin
              row_q <= 3'd0;
              col_q <= 3'd0;
              if (state_q == LOAD_A) begin
                state_q <= LOAD_B;
              end else begin
                state_q <= DONE;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else if (last_col) begin
              col_q <= 3'd0;
              row_q <= row_q + 3'd1;
            end else begin
              col_q <= col_q + 3'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.elem_ready   = loading;
  assign bus.m            = m_q;
  assign bus.n            = n_q;
  assign bus.matrices_out = mat_q;
  assign bus.valid        = valid_q;
  assign bus.busy         = busy_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_matrix_loader.sv
// ---------------------------------------------------------------------------
// tb_matrix_loader
//   Self-checking bench for matrix_loader. A reference model counts accepted
//   beats per load and places beat k directly into matrix k/(m*n) at row-major
//   position k%(m*n); all outputs are compared against it every cycle, plus
//   directed checks for the scenarios that matter most.
// ---------------------------------------------------------------------------
module tb_matrix_loader;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  matrix_loader_if bus_if ();

  matrix_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int n_checks  = 0;
  int n_pass    = 0;
  int n_fail    = 0;
  int cyc_count = 0;
  int start_cyc = 0;

  // Reference model state
  logic [7:0] ref_a [25];
  logic [7:0] ref_b [25];
  int         ref_m, ref_n, ref_k;
  bit         ref_loading, ref_valid, ref_busy, ref_error;

  logic [7:0] src_q [$];
  logic [7:0] last_beat;

  task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [399:0] ref_bus();
    logic [399:0] v;
    v = '0;
    for (int s = 0; s < 25; s++) begin
      v[s*8 +: 8]       = ref_a[s];
      v[200 + s*8 +: 8] = ref_b[s];
    end
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic ref_step();
    int mn, p, slot;
    if (reset) begin
      ref_loading = 0; ref_valid = 0; ref_busy = 0; ref_error = 0;
      ref_m = 0; ref_n = 0; ref_k = 0;
      for (int s = 0; s < 25; s++) begin ref_a[s] = 8'h00; ref_b[s] = 8'h00; end
    end else if (ref_loading) begin
      if (bus_if.elem_valid) begin
        mn   = ref_m * ref_n;
        p    = ref_k % mn;
        slot = (p / ref_n) * 5 + (p % ref_n);
        if (ref_k < mn) ref_a[slot] = bus_if.elem_data;
        else            ref_b[slot] = bus_if.elem_data;
        ref_k++;
        if (ref_k == 2 * mn) begin
          ref_loading = 0; ref_valid = 1; ref_busy = 0;
        end
      end
    end else if (bus_if.start) begin
      if (bus_if.m_in >= 1 && bus_if.m_in <= 5 && bus_if.n_in >= 1 && bus_if.n_in <= 5) begin
        ref_m = int'(bus_if.m_in); ref_n = int'(bus_if.n_in); ref_k = 0;
        for (int s = 0; s < 25; s++) begin ref_a[s] = 8'h00; ref_b[s] = 8'h00; end
        ref_loading = 1; ref_busy = 1; ref_valid = 0; ref_error = 0;
      end else begin
        ref_error = 1; ref_valid = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("valid",      bus_if.valid,        ref_valid);
    check("busy",       bus_if.busy,         ref_busy);
    check("error",      bus_if.error,        ref_error);
    check("elem_ready", bus_if.elem_ready,   ref_loading);
    check("m",          bus_if.m,            ref_m);
    check("n",          bus_if.n,            ref_n);
    check("bus",        bus_if.matrices_out, ref_bus());
  endtask

  task automatic cyc();
    @(posedge clk);
    ref_step();
    cyc_count++;
    #1;
    check_outputs();
  endtask

  task automatic do_start(input logic [2:0] mi, input logic [2:0] ni);
    bus_if.start = 1'b1;
    bus_if.m_in  = mi;
    bus_if.n_in  = ni;
    start_cyc    = cyc_count;
    cyc();
    bus_if.start = 1'b0;
  endtask

  // bubble: 0 = elem_valid held high, 3 = low every third cycle, else random
  task automatic feed(input int beats, input int bubble);
    int done;
    int budget;
    bit ev;
    bit acc;
    done   = 0;
    budget = 0;
    while (done < beats && budget < 1000) begin
      if (src_q.size() == 0) src_q.push_back(8'($urandom));
      bus_if.elem_data = src_q[0];
      case (bubble)
        0:       ev = 1'b1;
        3:       ev = (budget % 3) != 2;
        default: ev = 1'($urandom_range(0, 1));
      endcase
      bus_if.elem_valid = ev;
      acc = ev && ref_loading;
      cyc();
      if (acc) begin
        last_beat = src_q.pop_front();
        done++;
      end
      budget++;
    end
    bus_if.elem_valid = 1'b0;
    check("feed_beats", done, beats);
  endtask

  initial begin
    logic [399:0] mask;
    logic [399:0] exp_bus;
    logic [2:0]   mi, ni;

    reset             = 1'b1;
    bus_if.start      = 1'b0;
    bus_if.m_in       = 3'd0;
    bus_if.n_in       = 3'd0;
    bus_if.elem_data  = 8'h00;
    bus_if.elem_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // 2x3 load with elements 1..12 streamed back-to-back
    for (int v = 1; v <= 12; v++) src_q.push_back(8'(v));
    do_start(3'd2, 3'd3);
    feed(12, 0);
    check("lat_2x3", cyc_count - start_cyc, 13);
    check("a00_2x3", bus_if.matrices_out[7:0],     8'd1);
    check("a12_2x3", bus_if.matrices_out[63:56],   8'd6);
    check("b00_2x3", bus_if.matrices_out[207:200], 8'd7);
    check("b12_2x3", bus_if.matrices_out[263:256], 8'd12);
    mask = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) begin
        mask[(i*5+j)*8 +: 8]       = 8'hFF;
        mask[200 + (i*5+j)*8 +: 8] = 8'hFF;
      end
    check("unused_2x3", bus_if.matrices_out & ~mask, '0);
    check("m_2x3", bus_if.m, 3'd2);
    check("n_2x3", bus_if.n, 3'd3);

    // elem_valid while DONE must change nothing
    bus_if.elem_valid = 1'b1;
    bus_if.elem_data  = 8'hAA;
    cyc();
    cyc();
    bus_if.elem_valid = 1'b0;

    // 5x5 with a bubble every third cycle
    do_start(3'd5, 3'd5);
    feed(50, 3);
    check("last_byte_5x5", bus_if.matrices_out[399:392], last_beat);
    check("valid_5x5", bus_if.valid, 1'b1);

    // Illegal dimensions
    do_start(3'd0, 3'd3);
    check("err_m0", bus_if.error, 1'b1);
    check("rdy_m0", bus_if.elem_ready, 1'b0);
    bus_if.elem_valid = 1'b1;
    cyc();
    bus_if.elem_valid = 1'b0;
    do_start(3'd6, 3'd1);
    check("err_m6", bus_if.error, 1'b1);
    check("rdy_m6", bus_if.elem_ready, 1'b0);
    src_q.push_back(8'hFF);
    src_q.push_back(8'h01);
    do_start(3'd1, 3'd1);
    check("err_clear", bus_if.error, 1'b0);
    feed(2, 0);
    check("lat_1x1", cyc_count - start_cyc, 3);
    check("a00_1x1", bus_if.matrices_out[7:0],     8'hFF);
    check("b00_1x1", bus_if.matrices_out[207:200], 8'h01);

    // Reset in the middle of a 3x3 load
    do_start(3'd3, 3'd3);
    feed(5, 0);
    check("busy_mid", bus_if.busy, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_bus",   bus_if.matrices_out, '0);
    check("rst_valid", bus_if.valid, 1'b0);
    check("rst_busy",  bus_if.busy, 1'b0);
    check("rst_error", bus_if.error, 1'b0);
    check("rst_m",     bus_if.m, 3'd0);
    check("rst_n",     bus_if.n, 3'd0);
    check("rst_rdy",   bus_if.elem_ready, 1'b0);

    // start during LOAD_A, and start together with the final beat
    do_start(3'd2, 3'd2);
    feed(2, 0);
    bus_if.start = 1'b1; bus_if.m_in = 3'd5; bus_if.n_in = 3'd5;
    feed(1, 0);
    bus_if.start = 1'b0;
    feed(4, 0);
    bus_if.start = 1'b1; bus_if.m_in = 3'd1; bus_if.n_in = 3'd2;
    feed(1, 0);
    bus_if.start = 1'b0;
    check("ign_m",     bus_if.m, 3'd2);
    check("ign_n",     bus_if.n, 3'd2);
    check("ign_valid", bus_if.valid, 1'b1);
    check("ign_busy",  bus_if.busy, 1'b0);

    // Restart from DONE with 1x2
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    src_q.push_back(8'h44);
    do_start(3'd1, 3'd2);
    check("restart_valid", bus_if.valid, 1'b0);
    check("restart_bus",   bus_if.matrices_out, '0);
    feed(4, 0);
    exp_bus = '0;
    exp_bus[7:0]     = 8'h11;
    exp_bus[15:8]    = 8'h22;
    exp_bus[207:200] = 8'h33;
    exp_bus[215:208] = 8'h44;
    check("restart_1x2", bus_if.matrices_out, exp_bus);

    // Randomised loads, occasional illegal requests, random bubbles
    for (int t = 0; t < 10; t++) begin
      mi = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(1, 5));
      ni = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 5));
      do_start(mi, ni);
      if (ref_loading) feed(2 * ref_m * ref_n, 1);
      for (int k = 0; k < 3; k++) begin
        bus_if.elem_valid = 1'($urandom_range(0, 1));
        bus_if.elem_data  = 8'($urandom);
        cyc();
      end
      bus_if.elem_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
